core_gpr_scb: RTL



---
 rtl/core_gpr_scb_if.sv | 38 +++
 rtl/core_gpr_scb.sv | 89 ++++++++
 2 files changed

// File: rtl/core_gpr_scb_if.sv
// Decode/writeback register-access bundle shared by the GPR scoreboard and its requesters.
// Handshake: decode presents rs/rd fields every cycle and reads reg_rs_ready combinationally; dec_issue is valid&ready of decode, wbN_vld are single-cycle retire pulses with no back-pressure.
interface core_gpr_scb_if #(
    parameter int XLEN = 32
);
    logic            dec_rs1_vld;
    logic [4:0]      dec_rs1_idx;
    logic            dec_rs2_vld;
    logic [4:0]      dec_rs2_idx;
    logic            dec_rd_vld;
    logic [4:0]      dec_rd_idx;
    logic            dec_issue;
    logic            reg_rs_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb0_vld;
    logic [4:0]      wb0_idx;
    logic [XLEN-1:0] wb0_data;
    logic            wb1_vld;
    logic [4:0]      wb1_idx;
    logic [XLEN-1:0] wb1_data;
    logic [5:0]      scb_busy_cnt;
    logic            scb_err;

    modport master (
        output dec_rs1_vld, dec_rs1_idx, dec_rs2_vld, dec_rs2_idx,
        output dec_rd_vld, dec_rd_idx, dec_issue,
        output wb0_vld, wb0_idx, wb0_data, wb1_vld, wb1_idx, wb1_data,
        input  reg_rs_ready, rs1_data, rs2_data, scb_busy_cnt, scb_err
    );

    modport slave (
        input  dec_rs1_vld, dec_rs1_idx, dec_rs2_vld, dec_rs2_idx,
        input  dec_rd_vld, dec_rd_idx, dec_issue,
        input  wb0_vld, wb0_idx, wb0_data, wb1_vld, wb1_idx, wb1_data,
        output reg_rs_ready, rs1_data, rs2_data, scb_busy_cnt, scb_err
    );
endinterface

// File: rtl/core_gpr_scb.sv
// 32-entry GPR file with a per-register busy scoreboard, combinational operand read
// with optional writeback forwarding, and two retire ports (EXU=wb0, LSU=wb1).
module core_gpr_scb #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1
) (
    input logic            clk,
    input logic            rstn,
    core_gpr_scb_if.slave  bus
);

    logic [XLEN-1:0] gpr_q [32];
    logic [31:0]     busy_q, busy_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [31:0] wr0_vec, wr1_vec, set_vec, clr_vec, eff_busy;
    logic        ready;
    logic        wb0_unexp, wb1_unexp, wb_clash, bad_issue;

    always_comb begin
        wr0_vec = '0;
        wr1_vec = '0;
        set_vec = '0;
        if (bus.wb0_vld && bus.wb0_idx != 5'd0) wr0_vec = 32'b1 << bus.wb0_idx;
        if (bus.wb1_vld && bus.wb1_idx != 5'd0) wr1_vec = 32'b1 << bus.wb1_idx;
        if (bus.dec_issue && bus.dec_rd_vld && bus.dec_rd_idx != 5'd0)
            set_vec = 32'b1 << bus.dec_rd_idx;
    end

    // Forwarding lets a register retiring this cycle count as free for decode.
    assign clr_vec  = BYPASS ? (wr0_vec | wr1_vec) : 32'b0;
    assign eff_busy = busy_q & ~clr_vec;

    assign ready = ~(bus.dec_rs1_vld & eff_busy[bus.dec_rs1_idx])
                 & ~(bus.dec_rs2_vld & eff_busy[bus.dec_rs2_idx])
                 & ~(bus.dec_rd_vld  & eff_busy[bus.dec_rd_idx]);

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        val = gpr_q[idx];
        if (BYPASS && bus.wb0_vld && bus.wb0_idx == idx) val = bus.wb0_data;
        if (BYPASS && bus.wb1_vld && bus.wb1_idx == idx) val = bus.wb1_data;
        if (idx == 5'd0) val = '0;
        return val;
    endfunction

    assign bus.rs1_data     = read_port(bus.dec_rs1_idx);
    assign bus.rs2_data     = read_port(bus.dec_rs2_idx);
    assign bus.reg_rs_ready = ready;
    assign bus.scb_busy_cnt = cnt_q;
    assign bus.scb_err      = err_q;

    // A retire is expected only if the register is busy or is being claimed this cycle.
    assign wb0_unexp = (wr0_vec != '0) && ((wr0_vec & (busy_q | set_vec)) == '0);
    assign wb1_unexp = (wr1_vec != '0) && ((wr1_vec & (busy_q | set_vec)) == '0);
    assign wb_clash  = bus.wb0_vld && bus.wb1_vld && (bus.wb0_idx == bus.wb1_idx);
    assign bad_issue = bus.dec_issue && !ready;

    always_comb begin
        busy_d = ((busy_q & ~(wr0_vec | wr1_vec)) | set_vec) & 32'hFFFF_FFFE;
        err_d  = err_q | wb0_unexp | wb1_unexp | wb_clash | bad_issue;
        cnt_d  = '0;
        for (int i = 0; i < 32; i++) cnt_d = cnt_d + 6'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // wb1 is applied last so it owns the register on a same-index collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            if (wr0_vec != '0) gpr_q[bus.wb0_idx] <= bus.wb0_data;
            if (wr1_vec != '0) gpr_q[bus.wb1_idx] <= bus.wb1_data;
        end
    end

endmodule
